pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
- Parametrised fetch-PC generator for the pipelined core; successor to the plain incrementing PC register.
- Presents the next fetch address to the instruction-fetch stage with a valid/ready handshake.
- Supports branch/jump redirect from EX, trap vectoring, halt/resume, and an accepted-fetch counter.
- Sits at the head of IF; all redirect sources come from later stages.

Parameters:
- XLEN, 32, PC and target width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
- INSTR_BYTES, 4, increment per accepted fetch; power of two, at least 2
- CNT_W, 32, width of fetch_count

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc holds a fetchable address
- pc_ready  in  1  IF accepts pc this cycle
- redirect_valid  in  1  branch/jump taken in EX
- redirect_target  in  XLEN  branch/jump destination
- trap  in  1  exception/interrupt; vector to TRAP_VECTOR
- halt_req  in  1  stop issuing fetches
- halted  out  1  unit is in HALT
- fetch_count  out  CNT_W  number of accepted handshakes (pc_valid && pc_ready)

Behaviour:
- Reset (rst=1 at posedge), regardless of any other input:
  - pc=RESET_VECTOR, pc_valid=0, halted=0, fetch_count=0, state=BOOT.
- FSM states:
  - BOOT: one cycle with pc_valid=0, then RUN. trap in BOOT: pc<=TRAP_VECTOR, go to RUN. redirect_valid is ignored in BOOT.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1.
- Priority each cycle in RUN, highest first: trap > redirect_valid > halt_req > handshake advance > hold.
  - trap: pc<=TRAP_VECTOR next cycle; any simultaneous redirect is dropped; the handshake in that cycle still counts if it occurred.
  - redirect_valid: pc<=redirect_target next cycle, whether or not the current pc was accepted.
  - halt_req: if the handshake occurs this cycle, pc<=pc+INSTR_BYTES, then go to HALT. If no handshake, pc is held and the unit goes to HALT. The halted pc is the next address to fetch.
  - Handshake (pc_valid && pc_ready): pc<=pc+INSTR_BYTES.
  - Otherwise pc is held. pc must not change while pc_valid && !pc_ready, except on trap or redirect.
- HALT exits:
  - trap: pc<=TRAP_VECTOR, go to RUN.
  - redirect_valid: pc<=redirect_target, go to RUN.
  - halt_req deasserted: go to RUN with pc unchanged.
  - halt_req held high: stay in HALT.
- Latency: a redirect or trap seen at edge N produces the new pc with pc_valid=1 in the cycle after edge N.
- Arithmetic: pc+INSTR_BYTES is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0 with no flag.
- redirect_target low bits are taken as given (no alignment in base build).
- fetch_count increments by 1 per handshake and wraps at 2^CNT_W.
- Reset asserted mid-redirect or in HALT: reset wins and the sequence restarts at BOOT.

Optional Feature:
- Macro: PC_GEN_MISALIGN_TRAP_EN
- Defined:
  - A redirect_target with any of bits [log2(INSTR_BYTES)-1:0] nonzero is not taken; pc<=TRAP_VECTOR instead.
  - Extra output misalign_flag (1 bit) pulses high for exactly one cycle, aligned with the TRAP_VECTOR pc.
  - Flag reset value 0.
- Undefined:
  - Targets are loaded unmodified.
  - Port misalign_flag is absent.

Decomposition:
- Shared package cpu_pkg:
  - FSM state typedef pc_state_t {BOOT, RUN, HALT}.
  - XLEN default, RESET_VECTOR, TRAP_VECTOR, INSTR_BYTES constants.
- Sub-module pc_next_sel: combinational priority mux producing next_pc and next_state from trap/redirect/halt/handshake.
- Top level holds the pc, state and fetch_count registers.

Test Plan:
- rst high 2 cycles then low, pc_ready=1: pc_valid=0 for 1 cycle at 0x0, then pc=0x0,0x4,0x8; fetch_count=3 after 3 accepts.
- In RUN with pc=0x10 and pc_ready=0 for 3 cycles: pc stays 0x10, pc_valid=1, fetch_count unchanged.
- Same cycle trap=1, redirect_valid=1 target 0x400, pc_ready=1 at pc=0x20: next pc=0x100; fetch_count+1; 0x400 never appears.
- halt_req=1 with handshake at pc=0x30: halted=1, pc=0x34, pc_valid=0; then redirect to 0x80: RUN, pc=0x80 next cycle.
- Wrap: redirect to 0xFFFF_FFFC, then handshake: pc=0x0000_0000.
- With PC_GEN_MISALIGN_TRAP_EN: redirect target 0x202: pc=0x100 and misalign_flag=1 for one cycle. Without the macro: pc=0x202.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared types and default constants for the fetch-PC generator.
//   pc_state_t       : fetch FSM state (BOOT, RUN, HALT)
//   DEF_XLEN         : default PC / target width
//   DEF_RESET_VECTOR : default PC loaded on reset
//   DEF_TRAP_VECTOR  : default PC loaded on trap
//   DEF_INSTR_BYTES  : default PC increment per accepted fetch
//   DEF_CNT_W        : default width of the accepted-fetch counter
// ----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEF_INSTR_BYTES  = 4;
  localparam int unsigned DEF_CNT_W        = 32;

endpackage

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
// Combinational priority mux for the fetch-PC generator. From the current
// state, pc and the redirect sources it produces the next pc and next state.
// Priority in RUN: trap > redirect > halt_req > handshake advance > hold.
//
// Optional build macro: PC_GEN_MISALIGN_TRAP_EN
//   When defined, a redirect target that is not INSTR_BYTES-aligned is
//   replaced by TRAP_VECTOR and o_misalign is raised for that decision.
//
// Ports:
//   i_state           current FSM state
//   i_pc              current fetch address
//   i_trap            exception/interrupt request
//   i_redirect_valid  branch/jump taken in EX
//   i_redirect_target branch/jump destination
//   i_halt_req        stop issuing fetches
//   i_handshake       current pc accepted this cycle (pc_valid && pc_ready)
//   o_next_pc         pc for the next cycle
//   o_next_state      state for the next cycle
//   o_misalign        (macro only) misaligned redirect turned into a trap
// ----------------------------------------------------------------------------
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR),
  parameter int unsigned     INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  pc_state_t         i_state,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_trap,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_target,
  input  logic              i_halt_req,
  input  logic              i_handshake,
  output logic [XLEN-1:0]   o_next_pc,
  output pc_state_t         o_next_state
`ifdef PC_GEN_MISALIGN_TRAP_EN
  ,
  output logic              o_misalign
`endif
);

  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_misalign;

  // Wraps modulo 2^XLEN with no carry out.
  assign w_pc_inc = i_pc + XLEN'(INSTR_BYTES);

`ifdef PC_GEN_MISALIGN_TRAP_EN
  localparam int unsigned ALIGN_W = $clog2(INSTR_BYTES);

  assign w_misalign    = |i_redirect_target[ALIGN_W-1:0];
  assign w_redirect_pc = w_misalign ? TRAP_VECTOR : i_redirect_target;
`else
  // Base build takes the target exactly as given.
  assign w_misalign    = 1'b0;
  assign w_redirect_pc = i_redirect_target;
`endif

  logic w_misalign_taken;

  always_comb begin
    o_next_pc        = i_pc;
    o_next_state     = i_state;
    w_misalign_taken = 1'b0;

    unique case (i_state)
      BOOT: begin
        // Redirects are ignored while booting; only a trap can move the pc.
        o_next_state = RUN;
        if (i_trap) begin
          o_next_pc = TRAP_VECTOR;
        end
      end

      RUN: begin
        if (i_trap) begin
          o_next_pc = TRAP_VECTOR;
        end else if (i_redirect_valid) begin
          o_next_pc        = w_redirect_pc;
          w_misalign_taken = w_misalign;
        end else if (i_halt_req) begin
          // The halted pc is the next address still to be fetched.
          o_next_state = HALT;
          if (i_handshake) begin
            o_next_pc = w_pc_inc;
          end
        end else if (i_handshake) begin
          o_next_pc = w_pc_inc;
        end
      end

      HALT: begin
        if (i_trap) begin
          o_next_pc    = TRAP_VECTOR;
          o_next_state = RUN;
        end else if (i_redirect_valid) begin
          o_next_pc        = w_redirect_pc;
          o_next_state     = RUN;
          w_misalign_taken = w_misalign;
        end else if (!i_halt_req) begin
          o_next_state = RUN;
        end
      end

      default: begin
        o_next_state = BOOT;
      end
    endcase
  end

`ifdef PC_GEN_MISALIGN_TRAP_EN
  assign o_misalign = w_misalign_taken;
`else
  logic w_unused;
  assign w_unused = w_misalign_taken ^ w_misalign;
`endif

endmodule

// File: rtl/pc_gen_unit.sv
// ----------------------------------------------------------------------------
// pc_gen_unit
// Fetch-PC generator at the head of IF. Presents the next fetch address with
// a valid/ready handshake, follows redirects from EX and trap vectoring,
// supports halt/resume and counts accepted fetches.
//
// Optional build macro: PC_GEN_MISALIGN_TRAP_EN
//   Adds output misalign_flag and converts misaligned redirects into traps.
//
// Ports:
//   clk             core clock, rising edge
//   rst             synchronous reset, active-high
//   pc              current fetch address
//   pc_valid        pc holds a fetchable address (RUN)
//   pc_ready        IF accepts pc this cycle
//   redirect_valid  branch/jump taken in EX
//   redirect_target branch/jump destination
//   trap            exception/interrupt, vector to TRAP_VECTOR
//   halt_req        stop issuing fetches
//   halted          unit is in HALT
//   fetch_count     number of accepted handshakes, wraps at 2^CNT_W
//   misalign_flag   (macro only) one-cycle pulse with the TRAP_VECTOR pc
// ----------------------------------------------------------------------------
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int unsigned     INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int unsigned     CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  input  logic              pc_ready,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap,
  input  logic              halt_req,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
`ifdef PC_GEN_MISALIGN_TRAP_EN
  ,
  output logic              misalign_flag
`endif
);

  pc_state_t        r_state;
  pc_state_t        w_next_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_next_pc;
  logic [CNT_W-1:0] r_fetch_count;
  logic             w_pc_valid;
  logic             w_halted;
  logic             w_handshake;

  assign w_handshake = w_pc_valid && pc_ready;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign_flag;
`endif

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_next_sel (
    .i_state           (r_state),
    .i_pc              (r_pc),
    .i_trap            (trap),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_halt_req        (halt_req),
    .i_handshake       (w_handshake),
    .o_next_pc         (w_next_pc),
    .o_next_state      (w_next_state)
`ifdef PC_GEN_MISALIGN_TRAP_EN
    ,
    .o_misalign        (w_misalign)
`endif
  );

  // State and pc registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // Accepted-fetch counter; a trap or redirect does not cancel the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_handshake) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

`ifdef PC_GEN_MISALIGN_TRAP_EN
  // Registered so the pulse lines up with the TRAP_VECTOR pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_flag <= 1'b0;
    end else begin
      r_misalign_flag <= w_misalign;
    end
  end

  assign misalign_flag = r_misalign_flag;
`endif

  // Outputs decoded from state only.
  always_comb begin
    w_pc_valid = 1'b0;
    w_halted   = 1'b0;
    unique case (r_state)
      BOOT:    w_pc_valid = 1'b0;
      RUN:     w_pc_valid = 1'b1;
      HALT:    w_halted   = 1'b1;
      default: w_pc_valid = 1'b0;
    endcase
  end

  assign pc          = r_pc;
  assign pc_valid    = w_pc_valid;
  assign halted      = w_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        halt_req;
  logic        halted;
  logic [31:0] fetch_count;
`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic        misalign_flag;
`endif

  int n_checks;
  int n_fail;

  // Expected addresses of accepted fetches, in order.
  logic [31:0] sb[$];

  pc_gen_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .halt_req        (halt_req),
    .halted          (halted),
    .fetch_count     (fetch_count)
`ifdef PC_GEN_MISALIGN_TRAP_EN
    ,
    .misalign_flag   (misalign_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and checks happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted fetch.
  always @(negedge clk) begin
    if (!rst && pc_valid && pc_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_unexpected: got 0x%0h expected none", pc);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb.pop_front();
        if (pc !== exp_pc) begin
          n_fail++;
          $display("FAIL fetch_pc: got 0x%0h expected 0x%0h", pc, exp_pc);
        end
      end
    end
  end

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; pc_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    trap = 1'b0; halt_req = 1'b0;

    // Reset held for two edges.
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(pc_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", fetch_count, 32'd0);

    // BOOT cycle, then three accepted fetches.
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    rst = 1'b0;
    check("boot_valid", 32'(pc_valid), 32'd0);
    tick();
    check("run_valid", 32'(pc_valid), 32'd1);
    check("run_pc0", pc, 32'h0);
    tick(); tick(); tick();
    check("count_after_3", fetch_count, 32'd3);
    check("pc_after_3", pc, 32'hC);

    // Stall: pc holds at 0x10 while not ready.
    pc_ready = 1'b0;
    redirect_to(32'h10);
    for (int i = 0; i < 3; i++) begin
      check("stall_pc", pc, 32'h10);
      check("stall_valid", 32'(pc_valid), 32'd1);
      tick();
    end
    check("stall_count", fetch_count, 32'd3);

    // Trap beats simultaneous redirect; the handshake still counts.
    redirect_to(32'h20);
    check("pre_trap_pc", pc, 32'h20);
    sb.push_back(32'h20);
    trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400; pc_ready = 1'b1;
    tick();
    trap = 1'b0; redirect_valid = 1'b0; pc_ready = 1'b0;
    check("trap_pc", pc, 32'h100);
    check("trap_count", fetch_count, 32'd4);
    tick();
    check("trap_pc_hold", pc, 32'h100);

    // Halt with handshake, then redirect out of HALT.
    redirect_to(32'h30);
    sb.push_back(32'h30);
    halt_req = 1'b1; pc_ready = 1'b1;
    tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'h34);
    check("halt_valid", 32'(pc_valid), 32'd0);
    check("halt_count", fetch_count, 32'd5);
    tick();
    check("halt_stay", 32'(halted), 32'd1);
    pc_ready = 1'b0;
    redirect_to(32'h80);
    check("halt_exit_pc", pc, 32'h80);
    check("halt_exit_valid", 32'(pc_valid), 32'd1);
    check("halt_exit_halted", 32'(halted), 32'd0);

    // Halt without handshake, resume by dropping halt_req.
    tick();
    check("halt2_halted", 32'(halted), 32'd1);
    check("halt2_pc", pc, 32'h80);
    halt_req = 1'b0;
    tick();
    check("resume_valid", 32'(pc_valid), 32'd1);
    check("resume_pc", pc, 32'h80);

    // Wrap from top of address space.
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    sb.push_back(32'hFFFF_FFFC);
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    check("wrap_pc", pc, 32'h0);
    check("wrap_count", fetch_count, 32'd6);

    // Misaligned redirect target.
    redirect_to(32'h202);
`ifdef PC_GEN_MISALIGN_TRAP_EN
    check("misalign_pc", pc, 32'h100);
    check("misalign_flag", 32'(misalign_flag), 32'd1);
    tick();
    check("misalign_flag_off", 32'(misalign_flag), 32'd0);
`else
    check("unaligned_pc", pc, 32'h202);
`endif

    // Reset while halted restarts at BOOT.
    halt_req = 1'b1;
    tick();
    check("pre_rst_halted", 32'(halted), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; halt_req = 1'b0;
    check("rst_halt_pc", pc, 32'h0);
    check("rst_halt_halted", 32'(halted), 32'd0);
    check("rst_halt_valid", 32'(pc_valid), 32'd0);
    check("rst_halt_count", fetch_count, 32'd0);

    // Redirect ignored in BOOT.
    redirect_to(32'h44);
    check("boot_redirect_pc", pc, 32'h0);
    check("boot_redirect_valid", 32'(pc_valid), 32'd1);

    // Trap honoured in BOOT.
    rst = 1'b1;
    tick();
    rst = 1'b0; trap = 1'b1;
    tick();
    trap = 1'b0;
    check("boot_trap_pc", pc, 32'h100);
    check("boot_trap_valid", 32'(pc_valid), 32'd1);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
